// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: commits results to the register file, advances the
// architectural PC, counts retired instructions and raises the wrong-path squash.
module writeback_stage #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC     = 32'h0000_0000,
  parameter logic [63:0]       INSTRET_INIT = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_rd_value,
  input  logic            wb_redirect,
  input  logic [XLEN-1:0] wb_target_pc,
  input  logic            stall,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc_reg,
  output logic            flush,
  output logic            trap_misaligned,
  output logic [63:0]     instret
);

  // Handshake: an instruction is accepted on a cycle with wb_valid=1 and stall=0;
  // there is no backpressure to exec other than stall, and nothing is buffered.

  logic [XLEN-1:0] r_rf [0:31];
  logic [XLEN-1:0] r_pc;
  logic            r_flush;
  logic            r_trap;
  logic [63:0]     r_instret;

  logic            w_accept;
  logic            w_drop;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_retire;
  logic            w_rf_we;
  logic            w_unused_tgt_lsb;

  assign w_accept         = wb_valid & ~stall;
  assign w_drop           = w_accept & r_flush;
  assign w_target         = {wb_target_pc[XLEN-1:1], 1'b0};
  assign w_unused_tgt_lsb = wb_target_pc[0];
  // Misaligned redirects are only judged for instructions that are not squashed.
  assign w_misaligned     = w_accept & ~r_flush & wb_redirect & w_target[1];
  assign w_retire         = w_accept & ~r_flush & ~w_misaligned;
  assign w_rf_we          = w_retire & wb_we & (wb_rd != 5'd0) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      r_pc      <= RESET_PC;
      r_flush   <= 1'b0;
      r_trap    <= 1'b0;
      r_instret <= INSTRET_INIT;
    end else begin
      r_trap <= w_misaligned;
      if (w_rf_we) r_rf[wb_rd] <= wb_rd_value;
      if (w_drop) begin
        r_flush <= 1'b0;
      end else if (w_retire) begin
        r_instret <= r_instret + 64'd1;
        if (wb_redirect) begin
          r_pc    <= w_target;
          r_flush <= 1'b1;
        end else begin
          r_pc <= wb_pc + XLEN'(4);
        end
      end
    end
  end

  // Write-through bypass so decode sees a value in the same cycle it retires.
  always_comb begin
    rs1_data = r_rf[rs1_addr];
    rs2_data = r_rf[rs2_addr];
    if (w_rf_we && rs1_addr == wb_rd) rs1_data = wb_rd_value;
    if (w_rf_we && rs2_addr == wb_rd) rs2_data = wb_rd_value;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  assign pc_reg          = r_pc;
  assign flush           = r_flush;
  assign trap_misaligned = r_trap;
  assign instret         = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus random bench for writeback_stage: a reference model pushes the
// expected post-edge state into a queue, popped and compared after each edge.
module tb_writeback_stage;

  localparam int          EXP_W  = 98;
  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [63:0] INIT2  = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_rd_value;
  logic        wb_redirect;
  logic [31:0] wb_target_pc;
  logic        stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data, rs2_data, pc_reg;
  logic        flush, trap_misaligned;
  logic [63:0] instret;
  logic [31:0] rs1_data2, rs2_data2, pc_reg2;
  logic        flush2, trap_misaligned2;
  logic [63:0] instret2;

  writeback_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_rd_value(wb_rd_value), .wb_redirect(wb_redirect),
    .wb_target_pc(wb_target_pc), .stall(stall), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc_reg(pc_reg), .flush(flush), .trap_misaligned(trap_misaligned),
    .instret(instret)
  );

  // Second instance starts its counter near all-ones to exercise the 64-bit wrap.
  writeback_stage #(.XLEN(32), .RESET_PC(RST_PC), .INSTRET_INIT(INIT2)) dut_wrap (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_rd_value(wb_rd_value), .wb_redirect(wb_redirect),
    .wb_target_pc(wb_target_pc), .stall(stall), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data2), .rs2_data(rs2_data2),
    .pc_reg(pc_reg2), .flush(flush2), .trap_misaligned(trap_misaligned2),
    .instret(instret2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // reference model and scoreboard
  logic [31:0]      m_rf [32];
  logic [31:0]      m_pc;
  logic             m_flush;
  logic             m_trap;
  logic [63:0]      m_instret;
  logic [EXP_W-1:0] exp_q [$];
  int               n_pass;
  int               n_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic wr);
    if (a == 5'd0) return 32'h0;
    if (wr && a == wb_rd) return wb_rd_value;
    return m_rf[a];
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic we, input logic [31:0] val, input logic redir,
                       input logic [31:0] tgt, input logic stl,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb_valid     = v;
    wb_pc        = pc;
    wb_rd        = rd;
    wb_we        = we;
    wb_rd_value  = val;
    wb_redirect  = redir;
    wb_target_pc = tgt;
    stall        = stl;
    rs1_addr     = a1;
    rs2_addr     = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, a1, a2);
  endtask

  // One clock: check combinational reads, predict next state, clock, compare.
  task automatic cycle();
    logic [31:0]      t;
    logic             acc, ret, wr;
    logic [EXP_W-1:0] e;
    #1;
    acc = wb_valid && !stall;
    t   = {wb_target_pc[31:1], 1'b0};
    ret = !rst && acc && !m_flush && !(wb_redirect && t[1]);
    wr  = ret && wb_we && (wb_rd != 5'd0);
    if (!rst) begin
      chk("rs1_data", {32'h0, rs1_data}, {32'h0, exp_read(rs1_addr, wr)});
      chk("rs2_data", {32'h0, rs2_data}, {32'h0, exp_read(rs2_addr, wr)});
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_pc      = RST_PC;
      m_flush   = 1'b0;
      m_trap    = 1'b0;
      m_instret = 64'h0;
    end else begin
      m_trap = acc && !m_flush && wb_redirect && t[1];
      if (acc && m_flush) begin
        m_flush = 1'b0;
      end else if (ret) begin
        if (wr) m_rf[wb_rd] = wb_rd_value;
        if (wb_redirect) begin
          m_pc    = t;
          m_flush = 1'b1;
        end else begin
          m_pc = wb_pc + 32'd4;
        end
        m_instret = m_instret + 64'd1;
      end
    end
    exp_q.push_back({m_pc, m_flush, m_trap, m_instret});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc_reg", {32'h0, pc_reg}, {32'h0, e[97:66]});
    chk("flush", {63'h0, flush}, {63'h0, e[65]});
    chk("trap_misaligned", {63'h0, trap_misaligned}, {63'h0, e[64]});
    chk("instret", instret, e[63:0]);
    chk("instret_wrap", instret2, e[63:0] + INIT2);
    @(negedge clk);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    m_flush   = 1'b0;
    m_trap    = 1'b0;
    m_pc      = 32'h0;
    m_instret = 64'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;

    rst = 1'b1;
    idle(5'd0, 5'd0);
    cycle();
    cycle();
    rst = 1'b0;

    // plain retire with bypass, then storage read
    drive(1, 32'h100, 5'd5, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 5'd5, 5'd0);
    cycle();
    idle(5'd5, 5'd5);
    cycle();
    // write to x0 is ignored but still retires
    drive(1, 32'h104, 5'd0, 1, 32'h1234, 0, 32'h0, 0, 5'd0, 5'd5);
    cycle();
    idle(5'd0, 5'd0);
    cycle();
    // JAL then the squashed wrong-path instruction
    drive(1, 32'h200, 5'd1, 1, 32'h204, 1, 32'h400, 0, 5'd1, 5'd5);
    cycle();
    drive(1, 32'h204, 5'd2, 1, 32'h7, 0, 32'h0, 0, 5'd1, 5'd2);
    cycle();
    idle(5'd2, 5'd1);
    cycle();
    // JALR with odd target has bit 0 cleared
    drive(1, 32'h400, 5'd3, 1, 32'h404, 1, 32'h301, 0, 5'd3, 5'd0);
    cycle();
    drive(1, 32'h404, 5'd6, 1, 32'h55, 0, 32'h0, 0, 5'd6, 5'd3);
    cycle();
    // target with bit 1 set traps
    drive(1, 32'h300, 5'd4, 1, 32'h99, 1, 32'h302, 0, 5'd4, 5'd3);
    cycle();
    idle(5'd4, 5'd0);
    cycle();
    // redirect, then stalled valid cycles must not consume the squash
    drive(1, 32'h300, 5'd0, 0, 32'h0, 1, 32'h500, 0, 5'd0, 5'd0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h304, 5'd7, 1, 32'hAA, 0, 32'h0, 1, 5'd7, 5'd0);
      cycle();
    end
    drive(1, 32'h304, 5'd7, 1, 32'hAA, 0, 32'h0, 0, 5'd7, 5'd0);
    cycle();
    idle(5'd7, 5'd1);
    cycle();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 5) == 0),
            $urandom, 1'($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end

    // clear any pending squash, redirect, then reset mid-squash
    drive(1, 32'h600, 5'd0, 0, 32'h0, 0, 32'h0, 0, 5'd0, 5'd0);
    cycle();
    drive(1, 32'h604, 5'd8, 1, 32'h1, 1, 32'h800, 0, 5'd8, 5'd0);
    cycle();
    rst = 1'b1;
    drive(1, 32'h800, 5'd9, 1, 32'h2, 1, 32'h900, 1, 5'd9, 5'd8);
    cycle();
    rst = 1'b0;
    idle(5'd8, 5'd5);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
